pipe_hazard_ctrl: RTL

- Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) behind the CPU top with clock/start/i_datain/d_datain.
- Removes the need for software NOP padding between dependent instructions.
- Keeps a 3-deep scoreboard of in-flight destination registers, then stalls IF/ID and injects EX bubbles on RAW hazards.
- Flushes IF/ID and ID/EX when EX resolves a taken branch or jump (beq/bne/j/jal/jr).

---
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock for the 5-stage MIPS core: a 3-entry destination scoreboard drives stalls and EX bubbles, and taken redirects flush IF/ID and ID/EX.
// Define HAZARD_FWD_EN to stall only on load-use and to emit registered operand-forwarding selects.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              ex_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL} state_t;

    state_t            state, state_nxt;
    logic [3:1]        sb_v;
    logic [REG_AW-1:0] sb_rd [1:3];
    logic [3:1]        hit_rs, hit_rt, hit;
    logic              hazard, active, advance, s1_v;

    always_comb begin
        hit_rs = '0;
        hit_rt = '0;
        for (int k = 1; k <= 3; k++) begin
            hit_rs[k] = sb_v[k] & id_use_rs & (id_rs == sb_rd[k]);
            hit_rt[k] = sb_v[k] & id_use_rt & (id_rt == sb_rd[k]);
        end
        hit = hit_rs | hit_rt;
    end

`ifdef HAZARD_FWD_EN
    logic sb_ld1;
    assign hazard = id_valid & hit[1] & sb_ld1;
`else
    logic unused_ld;
    assign unused_ld = id_is_load;
    assign hazard    = id_valid & (|hit);
`endif

    assign active  = (state != S_IDLE);
    assign advance = active & id_valid & ~hazard & ~ex_redirect;
    // gr0 is never recorded, so a write to it can never create a match.
    assign s1_v    = advance & id_wr_en & (id_rd != '0);

    always_comb begin
        state_nxt  = state;
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        ex_bubble  = 1'b0;
        case (state)
            S_RUN, S_STALL: begin
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    ex_bubble  = 1'b1;
                    state_nxt  = S_RUN;
                end else if (hazard) begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    ex_bubble = 1'b1;
                    state_nxt = S_STALL;
                end else begin
                    state_nxt = S_RUN;
                end
                if (!start) state_nxt = S_IDLE;
            end
            default: begin
                pc_hold   = 1'b1;
                ifid_hold = 1'b1;
                ex_bubble = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            sb_v      <= '0;
            sb_rd[1]  <= '0;
            sb_rd[2]  <= '0;
            sb_rd[3]  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sb_v     <= {sb_v[2], sb_v[1], s1_v};
            sb_rd[3] <= sb_rd[2];
            sb_rd[2] <= sb_rd[1];
            sb_rd[1] <= id_rd;
            if (active && hazard && !ex_redirect && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (active && ex_redirect && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_pick(input logic [3:1] h);
        if (h[1])      return 2'b01;
        else if (h[2]) return 2'b10;
        else if (h[3]) return 2'b11;
        else           return 2'b00;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_ld1    <= 1'b0;
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
        end else begin
            sb_ld1    <= id_is_load;
            fwd_a_sel <= advance ? fwd_pick(hit_rs) : 2'b00;
            fwd_b_sel <= advance ? fwd_pick(hit_rt) : 2'b00;
        end
    end
`else
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

endmodule
